// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer: command opcodes and FSM states.
package jk_pkg;

    // {j,k} drive pattern carried by each command
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_TOG  = 2'b11
    } jk_op_t;

    // Sequencer states
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } jk_state_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers, synchronous flush and
// combinational head/occupancy/status views.
module jk_cmd_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata_c,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_level_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // Pointer update; flush wins over push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + LW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
        end
    end

    // Entry storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata_c = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level_c = r_wr_ptr - r_rd_ptr;
    assign o_full_c  = (o_level_c == LW'(DEPTH));
    assign o_empty_c = (o_level_c == '0);

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues HOLD/CLEAR/SET/TOGGLE commands and replays each as registered j/k
// levels for exactly its repeat count, back-to-back, with busy/done status.
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [CNT_W-1:0]       cmd_count,
    input  logic                   abort,
    output logic                   j,
    output logic                   k,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned W = 2 + CNT_W;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [W-1:0]     w_head;
    jk_op_t           w_head_op;
    logic [CNT_W-1:0] w_head_cnt;

    jk_state_t        r_state;
    jk_state_t        w_state_nxt;
    jk_op_t           r_op;
    jk_op_t           w_op_nxt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [1:0]       w_jk;

    // Ready is held low through reset and during an abort cycle
    assign cmd_ready = reset & ~w_full & ~abort;
    assign w_push    = cmd_valid & cmd_ready;

    jk_cmd_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_flush   (abort),
        .i_push    (w_push),
        .i_wdata   ({cmd_op, cmd_count}),
        .i_pop     (w_pop),
        .o_rdata_c (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_level_c (level)
    );

    assign w_head_op  = jk_op_t'(w_head[W-1:CNT_W]);
    assign w_head_cnt = w_head[CNT_W-1:0];

    // Next-state/next-output: pop and load the head whenever no drive cycle remains
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_op_nxt    = OP_HOLD;
            w_rem_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_op_nxt = OP_HOLD;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_cnt != '0) begin
                            w_state_nxt = S_DRIVE;
                            w_op_nxt    = w_head_op;
                            w_rem_nxt   = w_head_cnt;
                            w_done_nxt  = (w_head_cnt == CNT_W'(1));
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_rem > CNT_W'(1)) begin
                        w_rem_nxt  = r_rem - CNT_W'(1);
                        w_done_nxt = (r_rem == CNT_W'(2));
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_op_nxt    = OP_HOLD;
                        w_rem_nxt   = '0;
                        if (!w_empty) begin
                            w_pop = 1'b1;
                            if (w_head_cnt != '0) begin
                                w_state_nxt = S_DRIVE;
                                w_op_nxt    = w_head_op;
                                w_rem_nxt   = w_head_cnt;
                                w_done_nxt  = (w_head_cnt == CNT_W'(1));
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_op_nxt    = OP_HOLD;
                    w_rem_nxt   = '0;
                end
            endcase
        end
    end

    // State, drive pattern, remaining count and done pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_HOLD;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign w_jk = r_op;
    assign j    = w_jk[1];
    assign k    = w_jk[0];
    assign done = r_done;
    assign busy = (r_state == S_DRIVE) || (level != '0);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed plus randomized bench for jk_cmd_sequencer with a queue-based
// reference model and a downstream JK flip-flop.
module tb_jk_cmd_sequencer;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]       op;
        logic [CNT_W-1:0] cnt;
    } cmd_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             abort = 1'b0;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic [LW-1:0]    level;
    logic             ff_q;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;

    // Reference model: pending commands, cycles left on the active one
    cmd_t       m_q[$];
    int         m_left = 0;
    logic [1:0] m_op   = 2'b00;
    logic       m_ff   = 1'b0;
    bit         g_acc;

    jk_cmd_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .abort     (abort),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Downstream JK flip-flop fed by the sequencer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_left = 0;
        m_op   = 2'b00;
        m_ff   = 1'b0;
    endtask

    // Advance the model across one rising edge
    task automatic model_edge(input bit acc, input bit ab, input cmd_t c);
        logic [1:0] jk_now;
        cmd_t       h;
        jk_now = (m_left > 0) ? m_op : 2'b00;
        case (jk_now)
            2'b01:   m_ff = 1'b0;
            2'b10:   m_ff = 1'b1;
            2'b11:   m_ff = ~m_ff;
            default: m_ff = m_ff;
        endcase
        if (ab) begin
            m_q.delete();
            m_left = 0;
        end else begin
            if (m_left > 0) m_left--;
            if (m_left == 0 && m_q.size() > 0) begin
                h = m_q.pop_front();
                if (h.cnt != 0) begin
                    m_op   = h.op;
                    m_left = int'(h.cnt);
                end
            end
            if (acc) m_q.push_back(c);
        end
    endtask

    // One clock cycle: apply inputs, check ready, clock, check all outputs
    task automatic cyc(input bit v, input logic [1:0] op, input int cnt, input bit ab);
        bit   m_ready;
        cmd_t c;
        c.op      = op;
        c.cnt     = CNT_W'(cnt);
        cmd_valid = v;
        cmd_op    = op;
        cmd_count = CNT_W'(cnt);
        abort     = ab;
        #1;
        m_ready = (m_q.size() < DEPTH) && !ab;
        chk("ready", 32'(cmd_ready), 32'(m_ready));
        g_acc = v && m_ready;
        @(posedge clk);
        model_edge(g_acc, ab, c);
        #1;
        chk("jk",    32'({j, k}), 32'((m_left > 0) ? m_op : 2'b00));
        chk("done",  32'(done),   32'(m_left == 1));
        chk("busy",  32'(busy),   32'((m_left > 0) || (m_q.size() > 0)));
        chk("level", 32'(level),  32'(m_q.size()));
        chk("ff_q",  32'(ff_q),   32'(m_ff));
        if (done === 1'b1) n_done++;
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        int d0;
        int tries;
        logic [1:0] ops3 [5];
        int         cnts3 [5];

        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("rst_j",     32'(j),         32'd0);
        chk("rst_k",     32'(k),         32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_level", 32'(level),     32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        model_reset();
        #9 reset = 1'b1;

        // SET count=3 into an empty FIFO
        cyc(1, 2'b10, 3, 0);
        chk("s1_lvl", 32'(level), 32'd1);
        cyc(0, 2'b00, 0, 0);
        chk("s1_c1", 32'({j, k, done}), 32'b100);
        cyc(0, 2'b00, 0, 0);
        chk("s1_c2", 32'({j, k, done}), 32'b100);
        cyc(0, 2'b00, 0, 0);
        chk("s1_c3", 32'({j, k, done}), 32'b101);
        cyc(0, 2'b00, 0, 0);
        chk("s1_end", 32'({j, k, done, busy, ff_q}), 32'b00001);

        // TOGGLE 2 then CLEAR 1 back-to-back
        cyc(1, 2'b11, 2, 0);
        cyc(1, 2'b01, 1, 0);
        chk("s2_c1", 32'({j, k, done}), 32'b110);
        cyc(0, 2'b00, 0, 0);
        chk("s2_c2", 32'({j, k, done}), 32'b111);
        cyc(0, 2'b00, 0, 0);
        chk("s2_c3", 32'({j, k, done}), 32'b011);
        cyc(0, 2'b00, 0, 0);
        chk("s2_end", 32'({j, k, ff_q}), 32'b000);

        // SET 1, zero-count, CLEAR 1
        cyc(1, 2'b10, 1, 0);
        cyc(1, 2'b00, 0, 0);
        chk("s4_set", 32'({j, k, done}), 32'b101);
        cyc(1, 2'b01, 1, 0);
        chk("s4_gap", 32'({j, k, done}), 32'b000);
        cyc(0, 2'b00, 0, 0);
        chk("s4_clr", 32'({j, k, done}), 32'b011);
        cyc(0, 2'b00, 0, 0);

        // Long HOLD, then five commands with back-pressure
        ops3[0] = 2'b10; cnts3[0] = 2;
        ops3[1] = 2'b11; cnts3[1] = 1;
        ops3[2] = 2'b01; cnts3[2] = 3;
        ops3[3] = 2'b00; cnts3[3] = 1;
        ops3[4] = 2'b10; cnts3[4] = 1;
        d0 = n_done;
        cyc(1, 2'b00, 255, 0);
        for (int i = 0; i < 5; i++) begin
            tries = 0;
            do begin
                cyc(1, ops3[i], cnts3[i], 0);
                tries++;
            end while (!g_acc && tries < 400);
            chk("s3_accept_timeout", 32'(g_acc), 32'd1);
            if (i == 3) begin
                chk("s3_full_lvl",   32'(level),     32'd4);
                chk("s3_full_ready", 32'(cmd_ready), 32'd0);
            end
        end
        tries = 0;
        while (busy === 1'b1 && tries < 100) begin
            cyc(0, 2'b00, 0, 0);
            tries++;
        end
        chk("s3_drained", 32'(busy),         32'd0);
        chk("s3_dones",   32'(n_done - d0), 32'd6);

        // Abort during the 2nd TOGGLE cycle with two queued and a concurrent push
        cyc(1, 2'b11, 5, 0);
        cyc(1, 2'b10, 2, 0);
        cyc(1, 2'b01, 1, 0);
        chk("s5_pre", 32'({j, k, level}), {27'd0, 2'b11, 3'd2});
        cyc(1, 2'b10, 3, 1);
        chk("s5_abort", 32'({j, k, done, busy, level}), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 2'b00, 0, 0);
        chk("s5_after", 32'({j, k, busy, level}), 32'd0);

        // Asynchronous reset mid-SET count=4
        cyc(1, 2'b10, 4, 0);
        cyc(0, 2'b00, 0, 0);
        cyc(1, 2'b01, 2, 0);
        chk("s6_mid", 32'({j, k, busy}), 32'b101);
        #3 reset = 1'b0;
        #1;
        chk("s6_rst_jk",    32'({j, k}),    32'd0);
        chk("s6_rst_done",  32'(done),      32'd0);
        chk("s6_rst_busy",  32'(busy),      32'd0);
        chk("s6_rst_level", 32'(level),     32'd0);
        chk("s6_rst_ready", 32'(cmd_ready), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        cyc(1, 2'b11, 2, 0);
        cyc(0, 2'b00, 0, 0);
        chk("s6_rerun", 32'({j, k, done}), 32'b110);
        cyc(0, 2'b00, 0, 0);
        chk("s6_rerun2", 32'({j, k, done}), 32'b111);
        cyc(0, 2'b00, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 10) < 6, 2'($urandom % 4),
                (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 4)),
                ($urandom % 50) == 0);
        end
        tries = 0;
        while (busy === 1'b1 && tries < 200) begin
            cyc(0, 2'b00, 0, 0);
            tries++;
        end
        chk("rand_drained", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
